// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit port bundle: hazard/branch controls in, fetch PC, IMEM address and
// status out. Carries no handshake; pc_le/npc_le are level load-enables (0 = hold).
interface pc_fetch_unit_if #(
  parameter int IMEM_AW = 9
);
  logic               pc_le;
  logic               npc_le;
  logic               branch_taken;
  logic [31:0]        branch_target;
  logic [31:0]        pc_out;
  logic [31:0]        npc_out;
  logic [IMEM_AW-1:0] imem_addr;
  logic               if_id_le;
  logic               fetch_valid;
  logic               redirect_pending;
  logic               misalign_err;
  logic [15:0]        fetch_count;
  logic [1:0]         dbg_state;

  // Hazard unit / ID stage side.
  modport master (
    output pc_le, npc_le, branch_taken, branch_target,
    input  pc_out, npc_out, imem_addr, if_id_le, fetch_valid,
           redirect_pending, misalign_err, fetch_count, dbg_state
  );

  // Fetch unit side.
  modport slave (
    input  pc_le, npc_le, branch_taken, branch_target,
    output pc_out, npc_out, imem_addr, if_id_le, fetch_valid,
           redirect_pending, misalign_err, fetch_count, dbg_state
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// MIPS IF front end: PC/nPC pair with one delay slot, stall holding and a
// pending-redirect register for branches that arrive while stalled.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          IMEM_AW  = 9
) (
  input logic          clk,
  input logic          reset,
  pc_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic [31:0] r_pend_tgt;
  logic        r_pend;
  logic        r_misalign;
  logic        r_fetch_valid;
  logic [15:0] r_fetch_count;

  logic [31:0] w_pc;
  logic [31:0] w_npc;
  logic [31:0] w_pend_tgt;
  logic        w_pend;
  logic        w_misalign;
  logic        w_fetch_valid;
  logic [15:0] w_fetch_count;
  logic        w_adv;
  logic        w_tgt_misaligned;

  // A stall on either enable freezes the whole PC/nPC pair.
  assign w_adv            = bus.pc_le & bus.npc_le;
  assign w_tgt_misaligned = bus.branch_target[1:0] != 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_npc         <= RESET_PC + 32'd4;
      r_pend_tgt    <= 32'd0;
      r_pend        <= 1'b0;
      r_misalign    <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_count <= 16'd0;
    end else begin
      r_state       <= w_next_state;
      r_pc          <= w_pc;
      r_npc         <= w_npc;
      r_pend_tgt    <= w_pend_tgt;
      r_pend        <= w_pend;
      r_misalign    <= w_misalign;
      r_fetch_valid <= w_fetch_valid;
      r_fetch_count <= w_fetch_count;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_pc          = r_pc;
    w_npc         = r_npc;
    w_pend_tgt    = r_pend_tgt;
    w_pend        = r_pend;
    w_misalign    = r_misalign;
    w_fetch_valid = r_fetch_valid;
    w_fetch_count = r_fetch_count;
    case (r_state)
      BOOT: begin
        w_next_state  = RUN;
        w_fetch_valid = 1'b1;
      end
      RUN, STALL: begin
        if (w_adv) begin
          w_next_state  = RUN;
          w_pc          = r_npc;
          w_fetch_count = r_fetch_count + 16'd1;
          w_pend        = 1'b0;
          // A fresh branch beats a redirect held over from the stall.
          if (bus.branch_taken)  w_npc = bus.branch_target;
          else if (r_pend)       w_npc = r_pend_tgt;
          else                   w_npc = r_npc + 32'd4;
        end else begin
          w_next_state = STALL;
          if (bus.branch_taken) begin
            w_pend     = 1'b1;
            w_pend_tgt = bus.branch_target;
          end
        end
        if (bus.branch_taken && w_tgt_misaligned) w_misalign = 1'b1;
      end
      default: w_next_state = BOOT;
    endcase
  end

  assign bus.pc_out           = r_pc;
  assign bus.npc_out          = r_npc;
  assign bus.imem_addr        = r_pc[IMEM_AW-1:0];
  assign bus.if_id_le         = r_fetch_valid & w_adv;
  assign bus.fetch_valid      = r_fetch_valid;
  assign bus.redirect_pending = r_pend;
  assign bus.misalign_err     = r_misalign;
  assign bus.fetch_count      = r_fetch_count;
  assign bus.dbg_state        = r_state;

endmodule
